exp_series_ctrl: RTL and testbench
==================================

Name: exp_series_ctrl

Overview:
- Sequenced, multi-cycle evaluator of e^x by Taylor series: z = sum of x^i / i!, in decimal fixed-point (1.0 = SCALE).
- Accepts one operand over a valid/ready handshake.
- Per iteration: one multiply cycle, then one divide/accumulate cycle.
- Stops on a zero term, on the term limit, or on overflow; returns result, iteration count and an overflow flag over a valid/ready handshake.
- Clocked replacement for the combinational series evaluator; usable as a shared math resource.

Parameters:
- SCALE, 1000, fixed-point unit value (1.0).
- TERMS, 20, maximum series terms including the constant term; iterations i = 1..TERMS-1; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand x offered.
- in_ready  out  1  block can accept x; high only in IDLE.
- in_x  in  32  x, unsigned fixed-point (3000 = 3.0).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  e^x, unsigned fixed-point; saturates to 0xFFFFFFFF on overflow.
- out_iters  out  8  value of i at termination (number of iterations run).
- out_ovf  out  1  overflow occurred during this computation.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1 after release.
  - out_valid=0, out_result=0, out_iters=0, out_ovf=0.
  - Internal term, z, i, x and product registers all cleared.
  - Reset asserted mid-computation abandons it; no partial result is ever presented.
- IDLE: in_ready=1. On in_valid & in_ready at a clock edge: x<=in_x, term<=SCALE, z<=SCALE, i<=1, out_ovf<=0; go MUL.
- MUL: prod <= term * x (64-bit, unsigned, exact); go DIV.
- DIV:
  - q = prod / (i*SCALE), unsigned, truncating.
  - sum = z + q, evaluated at 33+ bits.
  - Overflow case: q > 0xFFFFFFFF or sum > 0xFFFFFFFF → z<=0xFFFFFFFF, out_ovf<=1, go DONE.
  - Normal case: term<=q, z<=sum.
  - Go DONE if q==0 or i==TERMS-1; otherwise i<=i+1, go MUL.
- DONE:
  - out_valid=1; out_result=z, out_iters=i, out_ovf stable until the handshake.
  - On out_valid & out_ready: out_valid<=0, go IDLE.
  - Outputs keep their last values after the handshake until the next computation overwrites them.
- Latency:
  - Handshake edge to out_valid high: 2N cycles, where N = out_iters. No early exit from the MUL state.
  - After the output handshake, in_ready is high the next cycle. No input is accepted in the same cycle the result is taken.
- in_valid while not IDLE is ignored; in_x is sampled only at the accepting edge.
- Back-pressure: out_ready held low keeps DONE and out_valid indefinitely with stable outputs.
- x=0: q=0 at i=1, result=SCALE, iters=1.
- Term reaching 0 stops the series even if TERMS is not yet reached. Truncation error is inherent and part of the spec.

Test Plan:
- Reset mid-run: accept x=3000, assert rst_n=0 at cycle 10 → out_valid=0, in_ready=1 after release, all outputs 0. Then x=1000 → result 2716, iters 7.
- x=3000, TERMS=20 → out_result=20082, out_iters=13, out_ovf=0, out_valid exactly 26 cycles after accept edge.
- x=1000 → out_result=2716, iters=7, 14 cycles latency.
- x=0 → out_result=1000, iters=1, 2 cycles latency.
- TERMS=5 instance, x=3000 → out_result=16375, iters=4 (term limit, term still nonzero).
- x=30000 → out_ovf=1, out_result=0xFFFFFFFF. Then hold out_ready=0 for 20 cycles → out_valid and outputs stable, in_ready=0 and in_valid pulses ignored. Release out_ready → IDLE next cycle; a new x=1000 gives 2716 with out_ovf=0.

Source files
------------

// File: rtl/exp_series_ctrl.sv
// Sequenced e^x evaluator: sums x^i/i! in decimal fixed point (1.0 = SCALE),
// one multiply cycle and one divide/accumulate cycle per series term.
module exp_series_ctrl #(
  parameter int unsigned SCALE = 1000,
  parameter int unsigned TERMS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [7:0]  out_iters,
  output logic        out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] x_r;
  logic [31:0] term;
  logic [31:0] z;
  logic [7:0]  i;
  logic [63:0] prod;
  logic        ovf;

  logic [63:0] divisor;
  logic [63:0] q;
  logic [64:0] sum;
  logic        ovf_hit;
  logic        stop;

  // Divide/accumulate datapath; divisor is never zero while in DIV since i >= 1.
  always_comb begin
    divisor = 64'(i) * 64'(SCALE);
    q       = (divisor != 64'd0) ? (prod / divisor) : 64'd0;
    sum     = {33'd0, z} + {1'b0, q};
    ovf_hit = (q[63:32] != 32'd0) || (sum[64:32] != 33'd0);
    stop    = (q == 64'd0) || (i == 8'(TERMS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = MUL;
        end
      end
      MUL: begin
        state_nxt = DIV;
      end
      DIV: begin
        if (ovf_hit || stop) begin
          state_nxt = DONE;
        end else begin
          state_nxt = MUL;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result registers double as the output holding registers, so they keep
  // their values after the handshake until the next operand is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r  <= 32'd0;
      term <= 32'd0;
      z    <= 32'd0;
      i    <= 8'd0;
      prod <= 64'd0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r  <= in_x;
            term <= 32'(SCALE);
            z    <= 32'(SCALE);
            i    <= 8'd1;
            ovf  <= 1'b0;
          end
        end
        MUL: begin
          prod <= 64'(term) * 64'(x_r);
        end
        DIV: begin
          if (ovf_hit) begin
            z   <= 32'hFFFF_FFFF;
            ovf <= 1'b1;
          end else begin
            term <= q[31:0];
            z    <= sum[31:0];
            if (!stop) begin
              i <= i + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_result = z;
  assign out_iters  = i;
  assign out_ovf    = ovf;

endmodule

// File: tb/tb_exp_series_ctrl.sv
// Bench for exp_series_ctrl: a TERMS=20 and a TERMS=5 instance share one input
// stream; results are compared with a plain-arithmetic series model.
module tb_exp_series_ctrl;

  localparam int SCALE = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_x;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [31:0] a_out_result;
  logic [7:0]  a_out_iters;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [31:0] b_out_result;
  logic [7:0]  b_out_iters;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exp_series_ctrl #(.SCALE(SCALE), .TERMS(20)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_x(in_x),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_result(a_out_result), .out_iters(a_out_iters), .out_ovf(a_out_ovf)
  );

  exp_series_ctrl #(.SCALE(SCALE), .TERMS(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_x(in_x),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_result(b_out_result), .out_iters(b_out_iters), .out_ovf(b_out_ovf)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // e^x as a truncating series: term_i = term_{i-1} * x / (i * SCALE).
  task automatic model(input logic [31:0] x, input int terms,
                       output logic [31:0] res, output logic [7:0] it, output logic ovf);
    logic [63:0] t, z, q;
    logic [64:0] s;
    int k;
    t = 64'(SCALE);
    z = 64'(SCALE);
    ovf = 1'b0;
    for (k = 1; k < terms; k++) begin
      q = (t * 64'(x)) / (64'(k) * 64'(SCALE));
      s = {1'b0, z} + {1'b0, q};
      if (s > 65'h0_FFFF_FFFF) begin
        ovf = 1'b1;
        z = 64'h0000_0000_FFFF_FFFF;
        break;
      end
      t = q;
      z = s[63:0];
      if (q == 64'd0) break;
    end
    it  = (k >= terms) ? 8'(terms - 1) : 8'(k);
    res = z[31:0];
  endtask

  task automatic apply_stimulus(input logic [31:0] x);
    @(negedge clk);
    check_output("a_in_ready_idle", 32'(a_in_ready), 32'd1);
    check_output("b_in_ready_idle", 32'(b_in_ready), 32'd1);
    in_valid = 1'b1;
    in_x = x;
    @(negedge clk);
    in_valid = 1'b0;
    in_x = $urandom;
  endtask

  task automatic run_op(input logic [31:0] x);
    logic [31:0] ra, rb;
    logic [7:0]  ia, ib;
    logic        oa, ob;
    int cycles, lat_a, lat_b;
    model(x, 20, ra, ia, oa);
    model(x, 5, rb, ib, ob);
    apply_stimulus(x);
    cycles = 0;
    lat_a = -1;
    lat_b = -1;
    while (lat_a < 0 && cycles < 1000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (b_out_valid && lat_b < 0) lat_b = cycles;
      if (a_out_valid) lat_a = cycles;
    end
    check_output("a_latency", 32'(lat_a), 32'(2 * ia));
    check_output("a_result", a_out_result, ra);
    check_output("a_iters", 32'(a_out_iters), 32'(ia));
    check_output("a_ovf", 32'(a_out_ovf), 32'(oa));
    check_output("b_latency", 32'(lat_b), 32'(2 * ib));
    check_output("b_result", b_out_result, rb);
    check_output("b_iters", 32'(b_out_iters), 32'(ib));
    check_output("b_ovf", 32'(b_out_ovf), 32'(ob));
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("a_valid_after_take", 32'(a_out_valid), 32'd0);
    check_output("a_ready_after_take", 32'(a_in_ready), 32'd1);
    check_output("b_valid_after_take", 32'(b_out_valid), 32'd0);
    check_output("b_ready_after_take", 32'(b_in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_valid", 32'(a_out_valid), 32'd0);
    check_output("rst_result", a_out_result, 32'd0);
    check_output("rst_iters", 32'(a_out_iters), 32'd0);
    check_output("rst_ovf", 32'(a_out_ovf), 32'd0);
    rst_n = 1'b1;

    // Abandon a run part-way through with an asynchronous reset.
    apply_stimulus(32'd3000);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid", 32'(a_out_valid), 32'd0);
    check_output("midrst_result", a_out_result, 32'd0);
    check_output("midrst_iters", 32'(a_out_iters), 32'd0);
    check_output("midrst_ovf", 32'(a_out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("midrst_in_ready", 32'(a_in_ready), 32'd1);
    check_output("midrst_valid_after", 32'(a_out_valid), 32'd0);
    run_op(32'd1000);
    check_output("x1_result_const", a_out_result, 32'd2716);
    check_output("x1_iters_const", 32'(a_out_iters), 32'd7);
    release_op();

    run_op(32'd3000);
    check_output("x3_result_const", a_out_result, 32'd20082);
    check_output("x3_iters_const", 32'(a_out_iters), 32'd13);
    check_output("x3_t5_result_const", b_out_result, 32'd16375);
    check_output("x3_t5_iters_const", 32'(b_out_iters), 32'd4);
    release_op();

    run_op(32'd0);
    check_output("x0_result_const", a_out_result, 32'd1000);
    check_output("x0_iters_const", 32'(a_out_iters), 32'd1);
    release_op();

    // Overflow, then back-pressure with ignored input pulses.
    run_op(32'd30000);
    check_output("ovf_flag_const", 32'(a_out_ovf), 32'd1);
    check_output("ovf_result_const", a_out_result, 32'hFFFF_FFFF);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = k[0];
      in_x = $urandom;
      check_output("hold_valid", 32'(a_out_valid), 32'd1);
      check_output("hold_result", a_out_result, 32'hFFFF_FFFF);
      check_output("hold_in_ready", 32'(a_in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_output("hold_ovf", 32'(a_out_ovf), 32'd1);
    release_op();
    run_op(32'd1000);
    check_output("post_ovf_result", a_out_result, 32'd2716);
    check_output("post_ovf_flag", 32'(a_out_ovf), 32'd0);
    release_op();

    for (int n = 0; n < 12; n++) begin
      run_op((n < 8) ? 32'($urandom_range(0, 8000)) : 32'($urandom_range(0, 40000)));
      release_op();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
